// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSRs with interrupt-enable stack, level interrupts, vectored mtvec and 64-bit counters
module csr_unit #(
  parameter int          IRQ_NUM     = 16,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          CNT_EN      = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [2:0]         opcode_i,
  input  logic [11:0]        addr_i,
  input  logic               csr_en_i,
  input  logic               write_enable_i,
  input  logic [31:0]        rs1_data_i,
  input  logic [31:0]        imm_data_i,
  input  logic               trap_i,
  input  logic [31:0]        mcause_i,
  input  logic [31:0]        pc_i,
  input  logic               mret_i,
  input  logic               instr_retired_i,
  input  logic [IRQ_NUM-1:0] irq_i,
  output logic [31:0]        read_data_o,
  output logic               illegal_o,
  output logic               irq_o,
  output logic [31:0]        irq_cause_o,
  output logic [31:0]        trap_pc_o,
  output logic [31:0]        mepc_o
);
  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  // interrupt lines live in mie/mip bits [16+IRQ_NUM-1:16]; stored here shifted down by 16
  localparam logic [16:0] IRQ_ONE  = 17'h1_0000 >> (16 - IRQ_NUM);
  localparam logic [15:0] IRQ_BITS = 16'(IRQ_ONE - 17'h1);

  logic        mie_bit_q, mie_bit_d, mpie_q, mpie_d;
  logic [15:0] mie_q, mie_d, mip_q, pend;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d, cyc_inc, ret_inc;
  logic [31:0] mstatus, op, wdata;
  logic        known, wr, hold;
  logic [3:0]  irq_idx;

  assign mstatus = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_bit_q, 3'b0};

  // read mux; unknown addresses read 0 and flag the access as unimplemented
  always_comb begin
    known = 1'b1;
    case (addr_i)
      A_MSTATUS:   read_data_o = mstatus;
      A_MIE:       read_data_o = {mie_q, 16'h0};
      A_MTVEC:     read_data_o = mtvec_q;
      A_MSCRATCH:  read_data_o = mscratch_q;
      A_MEPC:      read_data_o = mepc_q;
      A_MCAUSE:    read_data_o = mcause_q;
      A_MIP:       read_data_o = {mip_q, 16'h0};
      A_MCYCLE:    read_data_o = mcycle_q[31:0];
      A_MINSTRET:  read_data_o = minstret_q[31:0];
      A_MCYCLEH:   read_data_o = mcycle_q[63:32];
      A_MINSTRETH: read_data_o = minstret_q[63:32];
      default: begin
        read_data_o = '0;
        known = 1'b0;
      end
    endcase
  end

  assign illegal_o = csr_en_i & (~known | (write_enable_i & (addr_i == A_MIP)));
  assign op        = opcode_i[2] ? imm_data_i : rs1_data_i;
  assign wdata     = (opcode_i[1:0] == 2'b01) ? op :
                     (opcode_i[1:0] == 2'b10) ? (op | read_data_o) : (~op & read_data_o);
  assign wr        = write_enable_i & ~illegal_o & (opcode_i[1:0] != 2'b00);
  assign hold      = trap_i | mret_i;

  // next state: CSR writes first, then trap/mret override the trap-related registers
  always_comb begin
    mie_bit_d  = mie_bit_q;
    mpie_d     = mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    cyc_inc    = mcycle_q + 64'd1;
    ret_inc    = minstret_q + 64'(instr_retired_i);
    mcycle_d   = cyc_inc;
    minstret_d = ret_inc;
    if (wr) begin
      case (addr_i)
        A_MSTATUS: if (!hold) begin
          mie_bit_d = wdata[3];
          mpie_d    = wdata[7];
        end
        A_MIE:       mie_d      = wdata[31:16] & IRQ_BITS;
        A_MTVEC:     mtvec_d    = {wdata[31:2], (wdata[1:0] == 2'b01) ? 2'b01 : 2'b00};
        A_MSCRATCH:  mscratch_d = wdata;
        A_MEPC:      if (!hold) mepc_d = {wdata[31:2], 2'b00};
        A_MCAUSE:    if (!hold) mcause_d = wdata;
        A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wdata};
        A_MCYCLEH:   mcycle_d   = {wdata, cyc_inc[31:0]};
        A_MINSTRET:  minstret_d = {minstret_q[63:32], wdata};
        A_MINSTRETH: minstret_d = {wdata, ret_inc[31:0]};
        default: ;
      endcase
    end
    if (trap_i) begin
      mepc_d    = {pc_i[31:2], 2'b00};
      mcause_d  = mcause_i;
      mpie_d    = mie_bit_q;
      mie_bit_d = 1'b0;
    end else if (mret_i) begin
      mie_bit_d = mpie_q;
      mpie_d    = 1'b1;
    end
    if (!CNT_EN) begin
      mcycle_d   = '0;
      minstret_d = '0;
    end
  end

  // state registers; mip simply follows the interrupt lines one cycle late
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mie_bit_q  <= 1'b0;
      mpie_q     <= 1'b0;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_bit_q  <= mie_bit_d;
      mpie_q     <= mpie_d;
      mie_q      <= mie_d;
      mip_q      <= 16'(irq_i);
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign pend = mip_q & mie_q;

  // lowest-numbered pending and enabled line wins
  always_comb begin
    irq_idx = '0;
    for (int k = IRQ_NUM - 1; k >= 0; k--)
      if (pend[k]) irq_idx = 4'(k);
  end

  assign irq_o       = mie_bit_q & |pend;
  assign irq_cause_o = irq_o ? {1'b1, 26'b0, 1'b1, irq_idx} : 32'h0;
  assign trap_pc_o   = {mtvec_q[31:2], 2'b00} +
                       (((mtvec_q[1:0] == 2'b01) && mcause_i[31]) ? {25'b0, mcause_i[4:0], 2'b00} : 32'h0);
  assign mepc_o      = mepc_q;
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed and randomized checking of csr_unit against a behavioural model
module tb_csr_unit;
  localparam int IRQ_NUM = 16;
  localparam bit [31:0] IRQ_MASK = 32'(((64'd1 << IRQ_NUM) - 64'd1) << 16);
  localparam bit [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011, RWI = 3'b101, RSI = 3'b110, RCI = 3'b111;

  logic clk = 1'b0;
  logic rst, csr_en, we, trap, mret, retired;
  logic [2:0] opcode;
  logic [11:0] addr;
  logic [31:0] rs1, imm, mcause_in, pc;
  logic [IRQ_NUM-1:0] irq;
  logic [31:0] rdata, cause, trap_pc, mepc;
  logic illegal, irq_out;

  always #5 clk = ~clk;

  csr_unit #(.IRQ_NUM(IRQ_NUM), .MTVEC_RESET(32'h0), .CNT_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .addr_i(addr), .csr_en_i(csr_en),
    .write_enable_i(we), .rs1_data_i(rs1), .imm_data_i(imm), .trap_i(trap),
    .mcause_i(mcause_in), .pc_i(pc), .mret_i(mret), .instr_retired_i(retired),
    .irq_i(irq), .read_data_o(rdata), .illegal_o(illegal), .irq_o(irq_out),
    .irq_cause_o(cause), .trap_pc_o(trap_pc), .mepc_o(mepc)
  );

  int vectors = 0, miscompares = 0;
  bit m_mie, m_mpie;
  bit [31:0] m_mie_reg, m_mip, m_mtvec, m_scratch, m_mepc, m_mcause;
  bit [63:0] m_cyc, m_ret;
  bit [11:0] addrs [13] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                            12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h7C0, 12'h301};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] m_read(input bit [11:0] a, output bit legal);
    bit [31:0] v;
    legal = 1'b1;
    case (a)
      12'h300: v = 32'h1800 + (m_mie ? 32'h8 : 32'h0) + (m_mpie ? 32'h80 : 32'h0);
      12'h304: v = m_mie_reg;
      12'h305: v = m_mtvec;
      12'h340: v = m_scratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h344: v = m_mip;
      12'hB00: v = 32'(m_cyc % 64'h1_0000_0000);
      12'hB02: v = 32'(m_ret % 64'h1_0000_0000);
      12'hB80: v = 32'(m_cyc / 64'h1_0000_0000);
      12'hB82: v = 32'(m_ret / 64'h1_0000_0000);
      default: begin v = 0; legal = 1'b0; end
    endcase
    return v;
  endfunction

  function automatic bit [31:0] m_cause();
    if (!m_mie) return 0;
    for (int k = 0; k < IRQ_NUM; k++)
      if (m_mip[16+k] && m_mie_reg[16+k]) return 32'h8000_0000 + 32'(16 + k);
    return 0;
  endfunction

  function automatic bit [31:0] m_trap_pc();
    bit [31:0] base = m_mtvec & ~32'h3;
    return (m_mtvec % 4 == 1 && mcause_in[31]) ? base + 4 * (mcause_in % 32) : base;
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mip = 0; m_mtvec = 0;
    m_scratch = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ret = 0;
  endtask

  task automatic check_outputs();
    bit legal;
    bit [31:0] rd = m_read(addr, legal);
    check("read_data", rdata, rd);
    check("illegal", 32'(illegal), 32'(csr_en && (!legal || (we && addr == 12'h344))));
    check("irq", 32'(irq_out), 32'(m_cause() != 0));
    check("irq_cause", cause, m_cause());
    check("trap_pc", trap_pc, m_trap_pc());
    check("mepc", mepc, m_mepc);
  endtask

  task automatic model_step();
    bit legal, wr, hold;
    bit [31:0] old, op, nv;
    bit [63:0] ncyc, nret;
    if (rst) begin
      model_reset();
      return;
    end
    old  = m_read(addr, legal);
    op   = opcode >= 5 ? imm : rs1;
    nv   = (opcode % 4 == 1) ? op : (opcode % 4 == 2) ? (op | old) : (old & ~op);
    wr   = we && !(csr_en && (!legal || addr == 12'h344)) && (opcode % 4 != 0);
    hold = trap || mret;
    ncyc = m_cyc + 1;
    nret = m_ret + (retired ? 1 : 0);
    if (wr)
      case (addr)
        12'h300: if (!hold) begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mie_reg = nv & IRQ_MASK;
        12'h305: m_mtvec = (nv & ~32'h3) + ((nv % 4 == 1) ? 1 : 0);
        12'h340: m_scratch = nv;
        12'h341: if (!hold) m_mepc = nv & ~32'h3;
        12'h342: if (!hold) m_mcause = nv;
        12'hB00: ncyc = m_cyc - (m_cyc % 64'h1_0000_0000) + 64'(nv);
        12'hB80: ncyc = 64'(nv) * 64'h1_0000_0000 + ((m_cyc + 1) % 64'h1_0000_0000);
        12'hB02: nret = m_ret - (m_ret % 64'h1_0000_0000) + 64'(nv);
        12'hB82: nret = 64'(nv) * 64'h1_0000_0000 + ((m_ret + (retired ? 1 : 0)) % 64'h1_0000_0000);
        default: ;
      endcase
    m_cyc = ncyc;
    m_ret = nret;
    m_mip = (32'(irq) << 16) & IRQ_MASK;
    if (trap) begin
      m_mepc = pc & ~32'h3; m_mcause = mcause_in; m_mpie = m_mie; m_mie = 0;
    end else if (mret) begin
      m_mie = m_mpie; m_mpie = 1;
    end
  endtask

  task automatic tick();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input bit [2:0] o, input bit [11:0] a, input bit [31:0] d);
    opcode = o; addr = a; rs1 = d; imm = d; csr_en = 1; we = 1;
    tick();
    csr_en = 0; we = 0;
  endtask

  task automatic rd(input bit [11:0] a, input string tag, input bit [31:0] exp);
    addr = a; csr_en = 1; we = 0;
    #1 check(tag, rdata, exp);
    tick();
    csr_en = 0;
  endtask

  initial begin
    rst = 1; csr_en = 0; we = 0; trap = 0; mret = 0; retired = 0; opcode = 0; addr = 0;
    rs1 = 0; imm = 0; mcause_in = 0; pc = 0; irq = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 0;
    #1;
    check("rst_irq", 32'(irq_out), 0);
    check("rst_cause", cause, 0);
    check("rst_trap_pc", trap_pc, 0);
    check("rst_illegal", 32'(illegal), 0);
    rd(12'h305, "rst_mtvec", 32'h0);
    rd(12'h300, "rst_mstatus", 32'h1800);
    rd(12'h341, "rst_mepc", 32'h0);
    wr(RW, 12'h340, 32'hDEAD_BEEF);
    wr(RS, 12'h340, 32'h0000_00F0);
    rd(12'h340, "mscratch_rs", 32'hDEAD_BEFF);
    wr(RCI, 12'h340, 32'h0F);
    rd(12'h340, "mscratch_rci", 32'hDEAD_BEF0);
    wr(RW, 12'h304, 32'h0001_0000);
    wr(RW, 12'h300, 32'h8);
    irq = 16'h0001;
    #1 check("irq_not_yet", 32'(irq_out), 0);
    tick();
    #1 check("irq_on", 32'(irq_out), 1);
    check("irq_cause0", cause, 32'h8000_0010);
    irq = 0;
    tick();
    #1 check("irq_off", 32'(irq_out), 0);
    irq = 16'h0009;
    wr(RSI, 12'h304, 32'h0);
    wr(RS, 12'h304, 32'h0008_0000);
    #1 check("irq_prio", cause, 32'h8000_0010);
    wr(RC, 12'h304, 32'h0001_0000);
    #1 check("irq_prio3", cause, 32'h8000_0013);
    irq = 0;
    wr(RW, 12'h305, 32'h1001);
    rd(12'h300, "mstatus_pre_trap", 32'h1808);
    trap = 1; mcause_in = 32'h8000_0013; pc = 32'h200;
    #1 check("trap_pc_vec", trap_pc, 32'h104C);
    tick();
    trap = 0;
    #1 check("trap_mepc", mepc, 32'h200);
    rd(12'h300, "mstatus_trap", 32'h1880);
    mret = 1;
    tick();
    mret = 0;
    rd(12'h300, "mstatus_mret", 32'h1888);
    trap = 1; pc = 32'h300;
    wr(RW, 12'h341, 32'h55);
    trap = 0;
    #1 check("mepc_trap_wins", mepc, 32'h300);
    irq = 16'h0002;
    tick();
    opcode = RW; addr = 12'h344; rs1 = 32'hFFFF_FFFF; csr_en = 1; we = 1;
    #1 check("mip_write_illegal", 32'(illegal), 1);
    tick();
    we = 0;
    rd(12'h344, "mip_unchanged", 32'h0002_0000);
    irq = 0;
    addr = 12'h7C0; csr_en = 1;
    #1 check("unimpl_illegal", 32'(illegal), 1);
    check("unimpl_read", rdata, 0);
    tick();
    csr_en = 0;
    wr(RW, 12'h301, 32'h1234);
    rd(12'h340, "illegal_no_effect", 32'hDEAD_BEF0);
    wr(RW, 12'hB80, 32'h0);
    wr(RW, 12'hB00, 32'hFFFF_FFFF);
    tick();
    rd(12'hB80, "mcycleh_carry", 32'h1);
    rd(12'hB00, "mcycle_after", 32'h1);
    wr(RW, 12'hB02, 32'h0);
    wr(RW, 12'hB82, 32'h0);
    retired = 1; tick();
    retired = 0; tick(); tick();
    retired = 1; tick();
    retired = 0;
    rd(12'hB02, "minstret_pulses", 32'h2);
    rd(12'hB82, "minstreth", 32'h0);
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      trap = ($urandom_range(0, 11) == 0);
      mret = ($urandom_range(0, 11) == 0);
      mcause_in = $urandom;
      pc = $urandom;
      retired = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) irq = IRQ_NUM'($urandom);
      opcode = 3'($urandom_range(0, 7));
      addr = addrs[$urandom_range(0, 12)];
      csr_en = ($urandom_range(0, 3) != 0);
      we = csr_en && ($urandom_range(0, 1) == 1);
      rs1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      imm = $urandom_range(0, 31);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
